// File: rtl/matmul_sequencer.sv
// Matrix-multiply sequencer: drives the matrix register file to form C = A x B.
// Ports: in_clk/in_reset, in_start/out_busy/out_done handshake, out_rf_* file port, in_rf_data read data.
module matmul_sequencer #(
   parameter int size          = 4,
   parameter int address_width = 4,
   parameter int cell_width    = 32,
   parameter int width         = cell_width*size
) (
   input  logic                     in_clk,
   input  logic                     in_reset,
   input  logic                     in_start,
   output logic                     out_busy,
   output logic                     out_done,
   output logic [address_width-1:0] out_rf_address,
   output logic [width-1:0]         out_rf_data,
   output logic [1:0]               out_rf_type,
   output logic [1:0]               out_rf_select,
   output logic                     out_rf_read_en,
   output logic                     out_rf_write_en,
   input  logic [width-1:0]         in_rf_data
);

   localparam int idx_width = (size > 1) ? $clog2(size) : 1;
   localparam logic [idx_width-1:0] last_idx = idx_width'(size-1);
   localparam logic [address_width-1:0] size_a = address_width'(size);

   typedef enum logic [2:0] {
      S_IDLE, S_RD_A, S_RD_B, S_MAC, S_WR_C, S_DONE
   } state_t;

   state_t state_q, state_d;
   logic [idx_width-1:0] i_q, i_d, j_q, j_d;
   logic [address_width-1:0] addr_q, addr_d;
   logic [1:0] type_q, type_d, sel_q, sel_d;
   logic [width-1:0] row_a_q;
   logic [cell_width-1:0] acc_q, dot;
   logic a_load_q;

   // Dot product of the held row of A with the column of B on the read bus.
   always_comb begin
      dot = '0;
      for (int n = 0; n < size; n++) begin
         dot = dot + row_a_q[n*cell_width +: cell_width]
                   * in_rf_data[n*cell_width +: cell_width];
      end
   end

   always_comb begin
      state_d = state_q;
      i_d = i_q;
      j_d = j_q;
      unique case (state_q)
         S_IDLE: begin
            if (in_start) begin
               state_d = S_RD_A;
               i_d = '0;
               j_d = '0;
            end
         end
         S_RD_A: state_d = S_RD_B;
         S_RD_B: state_d = S_MAC;
         S_MAC:  state_d = S_WR_C;
         S_WR_C: begin
            if (j_q != last_idx) begin
               j_d = j_q + idx_width'(1);
               state_d = S_RD_B;
            end else if (i_q != last_idx) begin
               j_d = '0;
               i_d = i_q + idx_width'(1);
               state_d = S_RD_A;
            end else begin
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Address/type/select are loaded on entry to an access state and
   // otherwise hold, so they come straight from flops.
   always_comb begin
      addr_d = addr_q;
      type_d = type_q;
      sel_d  = sel_q;
      unique case (state_d)
         S_RD_A: begin
            addr_d = address_width'(i_d) * size_a;
            type_d = 2'b01;
            sel_d  = 2'b00;
         end
         S_RD_B: begin
            addr_d = address_width'(j_d);
            type_d = 2'b10;
            sel_d  = 2'b01;
         end
         S_WR_C: begin
            addr_d = address_width'(i_d) * size_a + address_width'(j_d);
            type_d = 2'b00;
            sel_d  = 2'b10;
         end
         default: ;
      endcase
   end

   always_ff @(posedge in_clk or negedge in_reset) begin
      if (!in_reset) begin
         state_q  <= S_IDLE;
         i_q      <= '0;
         j_q      <= '0;
         addr_q   <= '0;
         type_q   <= '0;
         sel_q    <= '0;
         row_a_q  <= '0;
         acc_q    <= '0;
         a_load_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         i_q      <= i_d;
         j_q      <= j_d;
         addr_q   <= addr_d;
         type_q   <= type_d;
         sel_q    <= sel_d;
         // Row data arrives during RD_B only when RD_B follows RD_A.
         a_load_q <= (state_q == S_RD_A);
         if (state_q == S_RD_B && a_load_q)
            row_a_q <= in_rf_data;
         if (state_q == S_MAC)
            acc_q <= dot;
      end
   end

   assign out_busy        = (state_q != S_IDLE);
   assign out_done        = (state_q == S_DONE);
   assign out_rf_read_en  = (state_q == S_RD_A) || (state_q == S_RD_B);
   assign out_rf_write_en = (state_q == S_WR_C);
   assign out_rf_address  = addr_q;
   assign out_rf_type     = type_q;
   assign out_rf_select   = sel_q;
   assign out_rf_data     = width'(acc_q);

endmodule

// File: tb/tb_matmul_sequencer.sv
// Testbench for matmul_sequencer: register-file model, matrix reference model,
// table-driven cases, random matrices and protocol/timing corner cases.
module tb_matmul_sequencer;

   logic         in_clk = 1'b0;
   logic         in_reset;
   logic         in_start;
   logic         out_busy, out_done;
   logic [3:0]   out_rf_address;
   logic [127:0] out_rf_data;
   logic [1:0]   out_rf_type, out_rf_select;
   logic         out_rf_read_en, out_rf_write_en;
   logic [127:0] in_rf_data = '0;

   matmul_sequencer dut (
      .in_clk(in_clk), .in_reset(in_reset), .in_start(in_start),
      .out_busy(out_busy), .out_done(out_done),
      .out_rf_address(out_rf_address), .out_rf_data(out_rf_data),
      .out_rf_type(out_rf_type), .out_rf_select(out_rf_select),
      .out_rf_read_en(out_rf_read_en), .out_rf_write_en(out_rf_write_en),
      .in_rf_data(in_rf_data)
   );

   always #5 in_clk = ~in_clk;

   logic [31:0] ma [4][4];
   logic [31:0] mb [4][4];
   logic [31:0] mc [16];
   logic [31:0] mexp [16];

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int start_cyc, done_cyc, done_cnt, b_cnt, both_cnt, hi_bad, proto_bad;
   int wq[$];
   int aq[$];

   typedef struct {
      string nm;
      logic [31:0] a00, b00, af, bf, c0, c15;
   } vec_t;
   vec_t tbl[5];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic logic [127:0] rf_read(logic [1:0] t, logic [1:0] s, logic [3:0] a);
      logic [127:0] d;
      d = '0;
      if (t == 2'b01 && s == 2'b00) begin
         for (int n = 0; n < 4; n++) d[n*32 +: 32] = ma[int'(a) / 4][n];
      end else if (t == 2'b10 && s == 2'b01) begin
         for (int n = 0; n < 4; n++) d[n*32 +: 32] = mb[n][int'(a) % 4];
      end
      return d;
   endfunction

   // Register file: read data registered on the read edge, C written on write edges.
   always @(posedge in_clk) begin
      cyc <= cyc + 1;
      if (out_rf_read_en)
         in_rf_data <= rf_read(out_rf_type, out_rf_select, out_rf_address);
      if (out_rf_write_en && out_rf_type == 2'b00 && out_rf_select == 2'b10)
         mc[out_rf_address] <= out_rf_data[31:0];
   end

   always @(negedge in_clk) begin
      if (in_reset) begin
         if (in_start && !out_busy) start_cyc = cyc;
         if (out_rf_read_en && out_rf_write_en) both_cnt++;
         if (out_rf_read_en) begin
            if (out_rf_select == 2'b00) begin
               aq.push_back(int'(out_rf_address));
               if (out_rf_type != 2'b01) proto_bad++;
            end else if (out_rf_select == 2'b01) begin
               b_cnt++;
               if (out_rf_type != 2'b10) proto_bad++;
            end else begin
               proto_bad++;
            end
         end
         if (out_rf_write_en) begin
            wq.push_back(int'(out_rf_address));
            if (out_rf_data[127:32] != '0) hi_bad++;
            if (out_rf_type != 2'b00 || out_rf_select != 2'b10) proto_bad++;
         end
         if (out_done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   task automatic compute_model();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            logic [31:0] s;
            s = '0;
            for (int n = 0; n < 4; n++) s = s + ma[r][n] * mb[n][c];
            mexp[r*4 + c] = s;
         end
   endtask

   task automatic fill(input logic [31:0] a00, b00, af, bf);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            ma[r][c] = af;
            mb[r][c] = bf;
         end
      ma[0][0] = a00;
      mb[0][0] = b00;
   endtask

   task automatic clear_counts();
      start_cyc = -1000;
      done_cyc = -1;
      done_cnt = 0;
      b_cnt = 0;
      both_cnt = 0;
      hi_bad = 0;
      proto_bad = 0;
      wq.delete();
      aq.delete();
      for (int k = 0; k < 16; k++) mc[k] = 32'hDEAD_BEEF;
   endtask

   task automatic do_run(input string nm, input int extra_at);
      int bad;
      clear_counts();
      compute_model();
      @(posedge in_clk); #1 in_start = 1'b1;
      @(posedge in_clk); #1 in_start = 1'b0;
      if (extra_at > 0) begin
         repeat (extra_at - 1) @(posedge in_clk);
         #1 in_start = 1'b1;
         @(posedge in_clk); #1 in_start = 1'b0;
      end
      for (int k = 0; k < 300 && done_cnt == 0; k++) @(negedge in_clk);
      chk({nm, " done_seen"}, 64'(done_cnt != 0), 64'd1);
      @(negedge in_clk);
      chk({nm, " busy_after"}, {62'd0, out_busy, out_done}, 64'd0);
      repeat (60) @(negedge in_clk);
      chk({nm, " latency"}, 64'(done_cyc - start_cyc), 64'd53);
      chk({nm, " done_pulses"}, 64'(done_cnt), 64'd1);
      chk({nm, " writes"}, 64'(wq.size()), 64'd16);
      bad = 0;
      foreach (wq[k]) if (wq[k] != k) bad++;
      chk({nm, " write_order"}, 64'(bad), 64'd0);
      chk({nm, " a_reads"}, 64'(aq.size()), 64'd4);
      bad = 0;
      foreach (aq[k]) if (aq[k] != 4*k) bad++;
      chk({nm, " a_addrs"}, 64'(bad), 64'd0);
      chk({nm, " b_reads"}, 64'(b_cnt), 64'd16);
      chk({nm, " rd_wr_overlap"}, 64'(both_cnt), 64'd0);
      chk({nm, " upper_bits"}, 64'(hi_bad), 64'd0);
      chk({nm, " type_select"}, 64'(proto_bad), 64'd0);
      bad = 0;
      for (int k = 0; k < 16; k++) if (mc[k] !== mexp[k]) bad++;
      chk({nm, " c_cells"}, 64'(bad), 64'd0);
   endtask

   initial begin
      int bad, w;
      tbl[0] = '{"const",  32'd2, 32'd3, 32'd2, 32'd3, 32'd24, 32'd24};
      tbl[1] = '{"ovf16",  32'h0001_0000, 32'h0001_0000, 32'd0, 32'd0, 32'd0, 32'd0};
      tbl[2] = '{"ovfmax", 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFE, 32'd0};
      tbl[3] = '{"mixed",  32'd5, 32'd7, 32'd1, 32'd1, 32'd38, 32'd4};
      tbl[4] = '{"wrap",   32'd3, 32'd1, 32'h8000_0001, 32'd2, 32'd9, 32'd8};

      in_reset = 1'b0;
      in_start = 1'b0;
      clear_counts();
      repeat (3) @(negedge in_clk);
      chk("reset_ctrl", {52'd0, out_busy, out_done, out_rf_read_en, out_rf_write_en,
          out_rf_type, out_rf_select, out_rf_address}, 64'd0);
      chk("reset_data", 64'(|out_rf_data), 64'd0);
      @(posedge in_clk); #1 in_reset = 1'b1;
      repeat (2) @(posedge in_clk);

      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            ma[r][c] = (r == c) ? 32'd1 : 32'd0;
            mb[r][c] = 32'(16*r + c);
         end
      do_run("identity", 0);
      bad = 0;
      for (int k = 0; k < 16; k++) if (mc[k] !== mb[k/4][k%4]) bad++;
      chk("identity c_eq_b", 64'(bad), 64'd0);

      foreach (tbl[t]) begin
         fill(tbl[t].a00, tbl[t].b00, tbl[t].af, tbl[t].bf);
         do_run(tbl[t].nm, 0);
         chk({tbl[t].nm, " c0"}, 64'(mc[0]), 64'(tbl[t].c0));
         chk({tbl[t].nm, " c15"}, 64'(mc[15]), 64'(tbl[t].c15));
      end

      for (int t = 0; t < 3; t++) begin
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
               ma[r][c] = $urandom;
               mb[r][c] = $urandom;
            end
         do_run("random", 0);
      end

      fill(32'd4, 32'd9, 32'd6, 32'd11);
      do_run("start_busy", 10);

      fill(32'd2, 32'd3, 32'd2, 32'd3);
      clear_counts();
      @(posedge in_clk); #1 in_start = 1'b1;
      @(posedge in_clk); #1 in_start = 1'b0;
      repeat (19) @(posedge in_clk);
      #2 in_reset = 1'b0;
      #1;
      chk("midreset_ctrl", {52'd0, out_busy, out_done, out_rf_read_en, out_rf_write_en,
          out_rf_type, out_rf_select, out_rf_address}, 64'd0);
      chk("midreset_data", 64'(|out_rf_data), 64'd0);
      w = wq.size();
      repeat (3) @(posedge in_clk);
      #1 chk("midreset_writes", 64'(wq.size()), 64'(w));
      @(posedge in_clk); #1 in_reset = 1'b1;
      repeat (2) @(posedge in_clk);
      do_run("restart", 0);
      bad = 0;
      for (int k = 0; k < 16; k++) if (mc[k] !== 32'd24) bad++;
      chk("restart c_24", 64'(bad), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/matmul_sequencer.md
Name: matmul_sequencer

Overview:
- Initiator-side controller for the coprocessor matrix register file: drives its address/type/select/enable port to compute C = A x B.
- Reads rows of A and columns of B through row/column accesses, forms each dot product and writes each C cell with a cell access.
- Sits between the coprocessor command decoder (start/done handshake) and the register file, and owns the file's port while busy.

Parameters:
- size, 4, matrix dimension k (k x k matrices); number of cells per row/column transfer
- address_width, 4, register-file address width; requires size*size <= 2**address_width
- cell_width, 32, bits per matrix element
- width, cell_width*size, bits per row/column transfer

Ports:
- in_clk  input  1  clock, rising edge
- in_reset  input  1  asynchronous, active-low reset
- in_start  input  1  start request, sampled in IDLE only
- out_busy  output  1  high from the cycle after an accepted start until DONE is exited
- out_done  output  1  one-cycle pulse when every C cell has been written
- out_rf_address  output  address_width  register-file address (0..k^2-1)
- out_rf_data  output  width  register-file write data
- out_rf_type  output  2  00 = cell, 01 = row, 10 = column
- out_rf_select  output  2  00 = A, 01 = B, 10 = C
- out_rf_read_en  output  1  register-file read enable
- out_rf_write_en  output  1  register-file write enable
- in_rf_data  input  width  register-file read data; valid one cycle after the read is issued

Behaviour:
- Reset: in_reset is asynchronous and active-low; clock is in_clk. While in reset, all outputs are 0 (type 00, select 00, address 0, data 0), the FSM is in IDLE, i = j = 0, and the row_a, col_b and acc registers are 0. Reset asserted mid-operation aborts the run, with no further register-file accesses; the partially written C is left as is.
- Register-file timing: the file registers its read data on the same edge that samples read_en. Data therefore appears on in_rf_data in the cycle after the read cycle.
- FSM outputs are registered, or decoded from registered state, with no combinational path from in_rf_data to the rf_* outputs.

States:
- IDLE: busy = 0, both enables 0. in_start = 1 -> RD_A, with i = 0 and j = 0.
- RD_A: read_en = 1, type = 01, select = 00, address = i*size. Next state RD_B.
- RD_B: read_en = 1, type = 10, select = 01, address = j. If the previous state was RD_A, row_a <= in_rf_data. Next state MAC.
- MAC: both enables 0. col_b <= in_rf_data, and acc <= sum over n = 0..size-1 of row_a[n]*col_b_in[n], where col_b_in is the in_rf_data value sampled this cycle. Element n is bits [n*cell_width +: cell_width]. Next state WR_C.
- WR_C: write_en = 1, type = 00, select = 10, address = i*size + j. out_rf_data[cell_width-1:0] = acc and upper bits = 0. Then:
  - j < size-1: j++ -> RD_B (row_a is reused, no re-read of A).
  - j = size-1 and i < size-1: j = 0, i++ -> RD_A.
  - j = size-1 and i = size-1: -> DONE.
- DONE: out_done = 1 for exactly one cycle, busy = 1, then IDLE (busy = 0).

Rules:
- Enables: read_en and write_en are never both 1. Outside RD_A/RD_B, read_en = 0; outside WR_C, write_en = 0. Address, type and select hold their last value when the enables are low.
- Arithmetic: elements are unsigned cell_width values. Each product and the running sum are truncated modulo 2**cell_width, which gives bit-identical results for two's-complement signed operands.
- Latency: busy spans size*(1 + 3*size) cycles (RD_A..WR_C) plus 1 DONE cycle. For size = 4: 52 + 1 = 53 cycles, with start sampled in IDLE at cycle 0 and out_done high in cycle 53.
- Access counts per run: exactly size reads of A, size^2 reads of B and size^2 writes of C, with C written in raster order (address 0..k^2-1).
- in_start while not in IDLE is ignored; it is not queued. in_start held high through DONE starts a new run on the cycle after DONE.
- The sequencer never addresses matrix select 11.

Test Plan:
- Identity: A = I, B[r][c] = 16*r + c (size 4) -> after out_done, C equals B; exactly 16 write_en pulses at addresses 0..15 in order.
- Constant: A all 2, B all 3 -> every C cell = 24; out_rf_data[127:32] = 0 on every write.
- Overflow: A[0][0] = B[0][0] = 0x0001_0000 and all other cells 0 -> C[0] = 0. A[0][0] = 0xFFFF_FFFF and B[0][0] = 2 -> C[0] = 0xFFFF_FFFE.
- Timing/protocol: after start in cycle 0, out_done pulses in cycle 53; read_en with select 00 occurs 4 times at addresses 0, 4, 8, 12; read_en and write_en are never high together; busy is 0 in cycle 54.
- Start while busy: pulse in_start at cycles 0 and 10 -> only one run, a single out_done, exactly 16 writes.
- Reset mid-run: drop in_reset asynchronously at cycle 20 -> all outputs 0 immediately. A restart after release then completes with correct C (constant case) and out_done 53 cycles after the new start.
